// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
// State encodings, opcode/funct values and ALU control codes.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational R-type funct to ALU control decode.
// valid is low for any funct the datapath does not implement.
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       valid
);

  always_comb begin
    alucont = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alucont = ALU_ADD;
      FN_SUB:  alucont = ALU_SUB;
      FN_AND:  alucont = ALU_AND;
      FN_OR:   alucont = ALU_OR;
      FN_SLT:  alucont = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath, stalling on memready.
// Optional MC_BNE_EN adds bne through the BRANCH state with inverted zero polarity.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       regwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       instret,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [2:0] fn_alucont;
  logic       fn_valid;
  logic       br_take;
  logic       pcen_c, regwrite_c, memwrite_c, irwrite_c, instret_c, illegal_c;

  alu_decoder u_alu_decoder (
    .funct   (funct),
    .alucont (fn_alucont),
    .valid   (fn_valid)
  );

`ifdef MC_BNE_EN
  // Branch polarity is captured while op is known to be the decoded instruction.
  logic bne_q;
  always_ff @(posedge clk) begin
    if (reset)
      bne_q <= 1'b0;
    else if (state_q == DECODE)
      bne_q <= (op == OP_BNE);
  end
  assign br_take = bne_q ? ~zero : zero;
`else
  assign br_take = zero;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    pcen_c     = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucont    = 3'b000;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    instret_c  = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        alucont   = ALU_ADD;
        irwrite_c = memready;
        pcen_c    = memready;
        state_d   = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        alucont = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE: begin
            if (fn_valid) state_d = EXECUTE;
            else          illegal_c = 1'b1;
          end
          OP_BEQ:  state_d = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:  state_d = BRANCH;
`endif
          OP_ADDI: state_d = ADDIEX;
          OP_J:    state_d = JUMP;
          default: illegal_c = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = ALU_ADD;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        instret_c  = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        instret_c  = memready;
        state_d    = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        alucont = fn_alucont;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        instret_c  = 1'b1;
      end
      BRANCH: begin
        alusrca   = 1'b1;
        alucont   = ALU_SUB;
        pcsrc     = 2'b01;
        pcen_c    = br_take;
        instret_c = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = ALU_ADD;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
        instret_c  = 1'b1;
      end
      JUMP: begin
        pcsrc     = 2'b10;
        pcen_c    = 1'b1;
        instret_c = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural side effects are suppressed for the whole reset window.
  assign pcen     = pcen_c     & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign irwrite  = irwrite_c  & ~reset;
  assign instret  = instret_c  & ~reset;
  assign illegal  = illegal_c  & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction table, corner sequences, random programs.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       pcen, regwrite, alusrca, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  logic       iord, memwrite, irwrite, instret, illegal;
  logic [3:0] state;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(pcen), .regwrite(regwrite), .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucont(alucont), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .instret(instret), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
  localparam int S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;

`ifdef MC_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [16:0] ov;
  assign ov = {pcen, regwrite, alusrca, memtoreg, regdst, alusrcb, pcsrc, alucont,
               iord, memwrite, irwrite, instret, illegal};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit op_ok(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
      6'b000000: return funct_ok(f);
      6'b000101: return BNE;
      default:   return 1'b0;
    endcase
  endfunction

  // Expected control word for one cycle, read straight off the per-state output table.
  function automatic logic [16:0] exp_out(input int st, input logic mr, input logic z,
                                          input logic [5:0] o, input logic [5:0] f);
    logic pc = 0, rw = 0, asa = 0, m2r = 0, rd = 0, io = 0, mw = 0, irw = 0, ir = 0, il = 0;
    logic [1:0] asb = 0, ps = 0;
    logic [2:0] ac = 0;
    case (st)
      S_FETCH:   begin asb = 2'b01; ac = 3'b010; irw = mr; pc = mr; end
      S_DECODE:  begin asb = 2'b11; ac = 3'b010; il = !op_ok(o, f); end
      S_MEMADR:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin m2r = 1; rw = 1; ir = 1; end
      S_MEMWR:   begin io = 1; mw = 1; ir = mr; end
      S_EXECUTE: begin asa = 1; ac = alu_of(f); end
      S_ALUWB:   begin rd = 1; rw = 1; ir = 1; end
      S_BRANCH:  begin asa = 1; ac = 3'b110; ps = 2'b01; ir = 1; pc = (o == 6'b000101) ? !z : z; end
      S_ADDIEX:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
      S_ADDIWB:  begin rw = 1; ir = 1; end
      S_JUMP:    begin ps = 2'b10; pc = 1; ir = 1; end
      default:   ;
    endcase
    return {pc, rw, asa, m2r, rd, asb, ps, ac, io, mw, irw, ir, il};
  endfunction

  typedef struct { int st; logic mr; } step_t;
  step_t q[$];

  function automatic step_t mk(input int st, input int mr);
    step_t s;
    s.st = st;
    s.mr = (mr < 0) ? 1'($urandom) : 1'(mr);
    return s;
  endfunction

  // Expected cycle-by-cycle state walk for one instruction, given stall counts.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int kf, input int km);
    q.delete();
    repeat (kf) q.push_back(mk(S_FETCH, 0));
    q.push_back(mk(S_FETCH, 1));
    q.push_back(mk(S_DECODE, -1));
    if (!op_ok(o, f)) return;
    case (o)
      6'b100011: begin
        q.push_back(mk(S_MEMADR, -1));
        repeat (km) q.push_back(mk(S_MEMRD, 0));
        q.push_back(mk(S_MEMRD, 1));
        q.push_back(mk(S_MEMWB, -1));
      end
      6'b101011: begin
        q.push_back(mk(S_MEMADR, -1));
        repeat (km) q.push_back(mk(S_MEMWR, 0));
        q.push_back(mk(S_MEMWR, 1));
      end
      6'b000000: begin q.push_back(mk(S_EXECUTE, -1)); q.push_back(mk(S_ALUWB, -1)); end
      6'b001000: begin q.push_back(mk(S_ADDIEX, -1));  q.push_back(mk(S_ADDIWB, -1)); end
      6'b000010: q.push_back(mk(S_JUMP, -1));
      default:   q.push_back(mk(S_BRANCH, -1));
    endcase
  endtask

  task automatic run_steps(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    foreach (q[i]) begin
      memready = q[i].mr;
      @(negedge clk);
      check("state", state, q[i].st);
      check("outputs", ov, exp_out(q[i].st, q[i].mr, z, o, f));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_count(input logic [5:0] o, input logic [5:0] f, input logic z,
                           output int cyc, output int rw, output int ir, output int pc, output int il);
    op = o; funct = f; zero = z; memready = 1'b1;
    cyc = 0; rw = 0; ir = 0; pc = 0; il = 0;
    do begin
      @(negedge clk);
      rw += regwrite; ir += instret; pc += pcen; il += illegal;
      cyc++;
      @(posedge clk); #1;
    end while (state != 4'd0 && cyc < 20);
  endtask

  typedef struct {
    logic [5:0] op; logic [5:0] funct; logic z;
    int cyc; int rw; int pc; int il;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int cyc, rw, ir, pc, il, mw, iat;
    logic [5:0] opl[8];
    logic [5:0] fnl[5];

    reset = 1'b1; op = 6'b100011; funct = 0; zero = 0; memready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", state, 0);
    check("reset_strobes", {pcen, regwrite, memwrite, irwrite, instret, illegal}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    vt.push_back('{6'b100011, 6'b000000, 1'b0, 5, 1, 1, 0});
    vt.push_back('{6'b101011, 6'b000000, 1'b0, 4, 0, 1, 0});
    vt.push_back('{6'b000000, 6'b100000, 1'b0, 4, 1, 1, 0});
    vt.push_back('{6'b000000, 6'b100010, 1'b1, 4, 1, 1, 0});
    vt.push_back('{6'b000000, 6'b100100, 1'b0, 4, 1, 1, 0});
    vt.push_back('{6'b000000, 6'b100101, 1'b0, 4, 1, 1, 0});
    vt.push_back('{6'b000000, 6'b101010, 1'b0, 4, 1, 1, 0});
    vt.push_back('{6'b000000, 6'b000000, 1'b0, 2, 0, 1, 1});
    vt.push_back('{6'b000100, 6'b000000, 1'b1, 3, 0, 2, 0});
    vt.push_back('{6'b000100, 6'b000000, 1'b0, 3, 0, 1, 0});
    vt.push_back('{6'b001000, 6'b000000, 1'b0, 4, 1, 1, 0});
    vt.push_back('{6'b000010, 6'b000000, 1'b0, 3, 0, 2, 0});
    vt.push_back('{6'b111111, 6'b100000, 1'b0, 2, 0, 1, 1});
    if (BNE) begin
      vt.push_back('{6'b000101, 6'b000000, 1'b0, 3, 0, 2, 0});
      vt.push_back('{6'b000101, 6'b000000, 1'b1, 3, 0, 1, 0});
    end else begin
      vt.push_back('{6'b000101, 6'b000000, 1'b0, 2, 0, 1, 1});
    end

    foreach (vt[i]) begin
      run_count(vt[i].op, vt[i].funct, vt[i].z, cyc, rw, ir, pc, il);
      check($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      check($sformatf("vec%0d_regwrite", i), rw, vt[i].rw);
      check($sformatf("vec%0d_pcen", i), pc, vt[i].pc);
      check($sformatf("vec%0d_illegal", i), il, vt[i].il);
      check($sformatf("vec%0d_instret", i), ir, vt[i].il ? 0 : 1);
    end

    // Directed per-cycle walks: lw, add, sub, slt, beq both ways, illegal op.
    build(6'b100011, 0, 0, 0);          run_steps(6'b100011, 0, 1'b0);
    build(6'b000000, 6'b100000, 0, 0);  run_steps(6'b000000, 6'b100000, 1'b0);
    build(6'b000000, 6'b100010, 0, 0);  run_steps(6'b000000, 6'b100010, 1'b0);
    build(6'b000000, 6'b101010, 0, 0);  run_steps(6'b000000, 6'b101010, 1'b0);
    build(6'b000100, 0, 0, 0);          run_steps(6'b000100, 0, 1'b1);
    build(6'b000100, 0, 0, 0);          run_steps(6'b000100, 0, 1'b0);
    build(6'b111111, 0, 0, 0);          run_steps(6'b111111, 0, 1'b0);

    // sw with three stall cycles in MEMWR.
    op = 6'b101011; funct = 0; memready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("sw_in_memwr", state, S_MEMWR);
    mw = 0; iat = -1;
    for (int i = 0; i < 4; i++) begin
      memready = (i == 3);
      @(negedge clk);
      mw += memwrite;
      if (instret) iat = i;
      @(posedge clk); #1;
    end
    check("sw_memwrite_cycles", mw, 4);
    check("sw_instret_cycle", iat, 3);
    check("sw_back_fetch", state, S_FETCH);

    // Reset while waiting in MEMRD abandons the load.
    op = 6'b100011; memready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memready = 1'b0;
    check("rst_in_memrd", state, S_MEMRD);
    reset = 1'b1; memready = 1'b1;
    @(negedge clk);
    check("rst_no_regwrite", {regwrite, instret, irwrite, pcen}, 0);
    @(posedge clk); #1;
    check("rst_state", state, S_FETCH);
    @(negedge clk);
    check("rst_hold_irwrite", irwrite, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_count(6'b100011, 0, 1'b0, cyc, rw, ir, pc, il);
    check("post_rst_lw_cycles", cyc, 5);
    check("post_rst_lw_regwrite", rw, 1);

    // Random programs with random stalls.
    opl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000000};
    fnl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] o, f;
      int k;
      k = $urandom_range(0, 8);
      o = (k == 8) ? 6'($urandom) : opl[k];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnl[$urandom_range(0, 4)];
      build(o, f, $urandom_range(0, 3), $urandom_range(0, 3));
      run_steps(o, f, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Moore-style control FSM that sequences the multicycle MIPS datapath. It decodes opcode/funct from the instruction register and drives every datapath control input cycle by cycle: PC enable, register write, ALU source selects, result/PC muxes and ALU operation. It also drives the memory-side strobes (`iord`, `memwrite`, `irwrite`) and stalls on a memory-ready handshake. It sits beside `datapath` in the multicycle top level.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: `instr[31:26]`.
- `funct` in 6: `instr[5:0]`.
- `zero` in 1: ALU zero flag from `datapath`.
- `memready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC load enable.
- `regwrite` out 1: register file write.
- `alusrca` out 1: 0 = pc, 1 = register A.
- `memtoreg` out 1: write-back source; 1 = readdata.
- `regdst` out 1: 1 = rd, 0 = rt.
- `alusrcb` out 2: 00 = rd2, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc` out 2: 00 = aluresult, 01 = aluout, 10 = jump target.
- `alucont` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `iord` out 1: memory address from aluout when 1, from pc when 0.
- `memwrite` out 1: data memory write strobe.
- `irwrite` out 1: instruction register load.
- `instret` out 1: one-cycle pulse on the last cycle of each retired instruction.
- `illegal` out 1: one-cycle pulse in DECODE for an unsupported op/funct.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Outputs not listed for a state are 0.
- FETCH:
  - `iord`=0, `alusrca`=0, `alusrcb`=01, `alucont`=010, `pcsrc`=00.
  - `irwrite`=`pcen`=`memready`.
  - Stays in FETCH while `memready`=0; goes to DECODE when it is 1.
- DECODE: `alusrca`=0, `alusrcb`=11, `alucont`=010 (branch target into aluout). Next state by `op`:
  - 100011 lw and 101011 sw → MEMADR
  - 000000 R-type → EXECUTE
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEX
  - 000010 j → JUMP
  - any other op → FETCH with `illegal`=1
- R-type funct 100000/100010/100100/100101/101010 maps to add/sub/and/or/slt. Any other funct in DECODE → FETCH with `illegal`=1.
- MEMADR: `alusrca`=1, `alusrcb`=10, `alucont`=010. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Holds until `memready`, then goes to MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1, `instret`=1; next FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Holds while `memready`=0; on `memready`=1 asserts `instret` and goes to FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `alucont` from funct; next ALUWB.
- ALUWB: `regdst`=1, `memtoreg`=0, `regwrite`=1, `instret`=1; next FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `alucont`=110, `pcsrc`=01, `pcen`=`zero`, `instret`=1; next FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10, `alucont`=010; next ADDIWB.
- ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1, `instret`=1; next FETCH.
- JUMP: `pcsrc`=10, `pcen`=1, `instret`=1; next FETCH.

## Timing
- Single state register; outputs are combinational from `state`, plus `memready` (FETCH, MEMWR) and `zero` (BRANCH).
- Cycles per instruction with `memready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. No strobe other than `memwrite` pulses during a stall; `memwrite` stays high for the whole MEMWR stay.
- `reset`=1 sampled at an edge sets `state`=FETCH. While `reset` is high, `pcen`, `regwrite`, `memwrite`, `irwrite`, `instret` and `illegal` are forced to 0.
- `reset` mid-instruction abandons the instruction; no write-back occurs.

## Configuration
- `MC_BNE_EN` defined: op 000101 (bne) decodes to BRANCH with `pcen`=!`zero`. The opcode is latched in DECODE to select the polarity.
- `MC_BNE_EN` undefined: op 000101 is illegal (`illegal` pulse, back to FETCH).

## Structure
- Shared package holds:
  - state enum (4-bit)
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`, `OP_J`
  - funct constants
  - ALU control constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`
- One sub-module, `alu_decoder`: combinational funct → `alucont` plus a valid flag, instantiated once.

## Test plan
- lw, `memready`=1: states 0→1→2→3→4→0; `regwrite`=1 only in cycle 5; `instret` pulses once.
- add (funct 100000): EXECUTE shows `alucont`=010, ALUWB `regdst`=1; sub shows 110, slt shows 111.
- beq:
  - `zero`=1 → `pcen`=1 with `pcsrc`=01 in BRANCH.
  - `zero`=0 → `pcen`=0; 3 cycles total either way.
- sw with `memready` low for 3 cycles in MEMWR: `memwrite` high 4 cycles, `instret` on the 4th.
- op 111111 → `illegal` pulse in DECODE, back in FETCH next cycle. With `MC_BNE_EN` undefined, op 000101 does the same; with it defined and `zero`=0, `pcen`=1.
- `reset` asserted in MEMRD → next `state`=0, no `regwrite`; fetch resumes normally after release.
